// File: rtl/spi_master_gen.sv
// spi_master_gen: SPI master with programmable SCLK divider, CPOL/CPHA, LSB-first and slave selects.
// Optional internal loopback (MOSI -> receive path) is built when SPI_MASTER_LOOPBACK_EN is defined.
module spi_master_gen #(
  parameter int DATA_W = 32,  // multiple of 8, 8..64
  parameter int NUM_SS = 4,   // 1..8
  parameter int DIV_W  = 8
) (
  input  logic                                          PCLK,
  input  logic                                          PRESETn,
  input  logic                                          start,
  input  logic [DATA_W-1:0]                             MWDATA,
  input  logic [((NUM_SS > 1) ? $clog2(NUM_SS) : 1)-1:0] ss_sel,
  input  logic [7:0]                                    SPICR_1,
  input  logic [7:0]                                    SPICR_2,
  input  logic [DIV_W-1:0]                              clk_div,
  input  logic                                          miso,
  output logic [DATA_W-1:0]                             MRDATA,
  output logic [7:0]                                    SPISR,
  output logic                                          busy,
  output logic [NUM_SS-1:0]                             ss_n,
  output logic                                          sclk,
  output logic                                          mosi
);

  localparam int SEL_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
  localparam int ECW   = $clog2(2 * DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [DIV_W-1:0]    div_reg, div_next;
  logic [DIV_W-1:0]    div_cnt_reg, div_cnt_next;
  logic [ECW-1:0]      edge_cnt_reg, edge_cnt_next;
  logic [DATA_W-1:0]   tx_reg, tx_next;
  logic [DATA_W-1:0]   rx_reg, rx_next;
  logic [DATA_W-1:0]   mrdata_reg, mrdata_next;
  logic [NUM_SS-1:0]   ss_n_reg, ss_n_next;
  logic                cpol_reg, cpol_next;
  logic                cpha_reg, cpha_next;
  logic                lsbfe_reg, lsbfe_next;
  logic                sclk_reg, sclk_next;
  logic                mosi_reg, mosi_next;
  logic                busy_reg, busy_next;
  logic                spif_reg, spif_next;
  logic                sptef_reg, sptef_next;

  logic                spe;
  logic                rx_bit;
  logic                half_done;
  logic                lead_edge;
  logic                last_edge;
  logic                tx_out;
  logic                tx_shift_out;
  logic [DATA_W-1:0]   tx_shift;
  logic [DATA_W-1:0]   rx_shift;
  logic [NUM_SS-1:0]   sel_dec;
  logic                unused_cfg;

  assign spe = SPICR_1[6];

  // One-hot decode of the requested slave; out-of-range indices match nothing.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SS; gi++) begin : g_sel
      assign sel_dec[gi] = (ss_sel == SEL_W'(gi));
    end
  endgenerate

`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_bit = SPICR_2[1] ? mosi_reg : miso;
`else
  assign rx_bit = miso;
`endif

  assign unused_cfg = ^{SPICR_1[7], SPICR_1[5:4], SPICR_2};

  assign half_done    = (div_cnt_reg == div_reg);
  assign lead_edge    = ~edge_cnt_reg[0];
  assign last_edge    = (edge_cnt_reg == ECW'(2 * DATA_W - 1));
  assign tx_out       = lsbfe_reg ? tx_reg[0] : tx_reg[DATA_W-1];
  assign tx_shift_out = lsbfe_reg ? tx_reg[1] : tx_reg[DATA_W-2];
  assign tx_shift     = lsbfe_reg ? {1'b0, tx_reg[DATA_W-1:1]} : {tx_reg[DATA_W-2:0], 1'b0};
  assign rx_shift     = lsbfe_reg ? {rx_bit, rx_reg[DATA_W-1:1]} : {rx_reg[DATA_W-2:0], rx_bit};

  always_comb begin
    state_next    = state_reg;
    div_next      = div_reg;
    div_cnt_next  = div_cnt_reg;
    edge_cnt_next = edge_cnt_reg;
    tx_next       = tx_reg;
    rx_next       = rx_reg;
    mrdata_next   = mrdata_reg;
    ss_n_next     = ss_n_reg;
    cpol_next     = cpol_reg;
    cpha_next     = cpha_reg;
    lsbfe_next    = lsbfe_reg;
    sclk_next     = sclk_reg;
    mosi_next     = mosi_reg;
    busy_next     = busy_reg;
    spif_next     = spif_reg;
    sptef_next    = sptef_reg;

    case (state_reg)
      IDLE: begin
        if (start && spe) begin
          cpol_next     = SPICR_1[3];
          cpha_next     = SPICR_1[2];
          lsbfe_next    = SPICR_1[0];
          div_next      = clk_div;
          tx_next       = MWDATA;
          rx_next       = '0;
          div_cnt_next  = '0;
          edge_cnt_next = '0;
          sclk_next     = SPICR_1[3];
          ss_n_next     = SPICR_1[1] ? ~sel_dec : '1;
          // CPHA=0 must present the first bit before the first (sampling) edge.
          mosi_next     = SPICR_1[2] ? 1'b0 : (SPICR_1[0] ? MWDATA[0] : MWDATA[DATA_W-1]);
          busy_next     = 1'b1;
          spif_next     = 1'b0;
          sptef_next    = 1'b0;
          state_next    = SETUP;
        end
      end

      SETUP: begin
        if (half_done) begin
          div_cnt_next = '0;
          state_next   = XFER;
        end else begin
          div_cnt_next = div_cnt_reg + DIV_W'(1);
        end
      end

      XFER: begin
        if (half_done) begin
          div_cnt_next  = '0;
          sclk_next     = ~sclk_reg;
          edge_cnt_next = edge_cnt_reg + ECW'(1);
          if (lead_edge == cpha_reg) begin
            // Driving edge: leading for CPHA=1, trailing for CPHA=0.
            if (cpha_reg) begin
              mosi_next = tx_out;
            end else begin
              mosi_next = tx_shift_out;
            end
            tx_next = tx_shift;
          end else begin
            rx_next = rx_shift;
          end
          if (last_edge) begin
            edge_cnt_next = '0;
            state_next    = HOLD;
          end
        end else begin
          div_cnt_next = div_cnt_reg + DIV_W'(1);
        end
      end

      HOLD: begin
        if (half_done) begin
          div_cnt_next = '0;
          ss_n_next    = '1;
          mosi_next    = 1'b0;
          mrdata_next  = rx_reg;
          spif_next    = 1'b1;
          sptef_next   = 1'b1;
          busy_next    = 1'b0;
          state_next   = IDLE;
        end else begin
          div_cnt_next = div_cnt_reg + DIV_W'(1);
        end
      end

      default: state_next = IDLE;
    endcase

    // Disabling the peripheral mid-frame abandons the frame without publishing it.
    if (state_reg != IDLE && !spe) begin
      state_next    = IDLE;
      div_cnt_next  = '0;
      edge_cnt_next = '0;
      ss_n_next     = '1;
      sclk_next     = cpol_reg;
      mosi_next     = 1'b0;
      busy_next     = 1'b0;
      sptef_next    = 1'b1;
      mrdata_next   = mrdata_reg;
      spif_next     = spif_reg;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      state_reg    <= IDLE;
      div_reg      <= '0;
      div_cnt_reg  <= '0;
      edge_cnt_reg <= '0;
      tx_reg       <= '0;
      rx_reg       <= '0;
      mrdata_reg   <= '0;
      ss_n_reg     <= '1;
      cpol_reg     <= 1'b0;
      cpha_reg     <= 1'b0;
      lsbfe_reg    <= 1'b0;
      sclk_reg     <= 1'b0;
      mosi_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      spif_reg     <= 1'b0;
      sptef_reg    <= 1'b1;
    end else begin
      state_reg    <= state_next;
      div_reg      <= div_next;
      div_cnt_reg  <= div_cnt_next;
      edge_cnt_reg <= edge_cnt_next;
      tx_reg       <= tx_next;
      rx_reg       <= rx_next;
      mrdata_reg   <= mrdata_next;
      ss_n_reg     <= ss_n_next;
      cpol_reg     <= cpol_next;
      cpha_reg     <= cpha_next;
      lsbfe_reg    <= lsbfe_next;
      sclk_reg     <= sclk_next;
      mosi_reg     <= mosi_next;
      busy_reg     <= busy_next;
      spif_reg     <= spif_next;
      sptef_reg    <= sptef_next;
    end
  end

  assign MRDATA = mrdata_reg;
  assign SPISR  = {spif_reg, 1'b0, sptef_reg, 5'b0};
  assign busy   = busy_reg;
  assign ss_n   = ss_n_reg;
  assign sclk   = sclk_reg;
  assign mosi   = mosi_reg;

endmodule

// File: tb/tb_spi_master_gen.sv
// Directed bench for spi_master_gen: reset, loopback, modes 1-3 against a slave model,
// LSB-first, slave-select control, SPE abort and reset during a frame.
`timescale 1ns/1ps
module tb_spi_master_gen;
  localparam int DATA_W = 32;
  localparam int NUM_SS = 4;
  localparam int DIV_W  = 8;

  logic              PCLK = 1'b0;
  logic              PRESETn = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] MWDATA = '0;
  logic [1:0]        ss_sel = '0;
  logic [7:0]        SPICR_1 = '0;
  logic [7:0]        SPICR_2 = '0;
  logic [DIV_W-1:0]  clk_div = '0;
  logic              miso;
  logic [DATA_W-1:0] MRDATA;
  logic [7:0]        SPISR;
  logic              busy;
  logic [NUM_SS-1:0] ss_n;
  logic              sclk;
  logic              mosi;

  int n_checks = 0;
  int n_fail   = 0;

  spi_master_gen #(.DATA_W(DATA_W), .NUM_SS(NUM_SS), .DIV_W(DIV_W)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .start(start), .MWDATA(MWDATA), .ss_sel(ss_sel),
    .SPICR_1(SPICR_1), .SPICR_2(SPICR_2), .clk_div(clk_div), .miso(miso),
    .MRDATA(MRDATA), .SPISR(SPISR), .busy(busy), .ss_n(ss_n), .sclk(sclk), .mosi(mosi)
  );

  always #5 PCLK = ~PCLK;

  // Slave model: shifts out a fixed word MSB first; changes data on the
  // non-sampling SCLK edge of the selected phase.
  logic [31:0] slv_word = 32'h3C5A9601;
  logic        loop_ext = 1'b0;
  logic        cur_cpol = 1'b0;
  logic        cur_cpha = 1'b0;
  logic        slv_miso = 1'b0;
  logic        sclk_last = 1'b0;
  int          slv_edges = 0;

  always @(negedge PCLK) begin
    int idx;
    if (busy !== 1'b1) begin
      slv_edges = 0;
      sclk_last = cur_cpol;
    end else if (sclk !== sclk_last) begin
      slv_edges = slv_edges + 1;
      sclk_last = sclk;
    end
    if (cur_cpha) idx = (slv_edges > 0) ? (slv_edges - 1) / 2 : 0;
    else          idx = slv_edges / 2;
    if (idx > 31) idx = 31;
    slv_miso = slv_word[31 - idx];
  end

  assign miso = loop_ext ? mosi : slv_miso;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one frame; disturbs latched inputs mid-frame (SPE kept) and records
  // busy length, the MOSI bit stream (first bit ends up in the MSB) and ss_n.
  task automatic do_xfer(input logic [7:0] cr1, input logic [7:0] div, input logic [31:0] data,
                         input logic [1:0] sel, output int cyc, output logic [31:0] cap,
                         output logic [3:0] ss_seen, output logic ss_ok);
    logic sprev;
    @(negedge PCLK);
    cur_cpol = cr1[3];
    cur_cpha = cr1[2];
    SPICR_1 = cr1; clk_div = div; MWDATA = data; ss_sel = sel;
    @(negedge PCLK);
    start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
    SPICR_1 = cr1 ^ 8'h0F; clk_div = div + 8'd5; MWDATA = ~data; ss_sel = sel + 2'd1;
    cyc = 0; cap = '0; ss_seen = ss_n; ss_ok = 1'b1; sprev = cr1[3];
    while (busy === 1'b1 && cyc < 5000) begin
      cyc++;
      if (ss_n !== ss_seen) ss_ok = 1'b0;
      if (sclk !== sprev) begin
        if (sclk !== cr1[3]) cap = {cap[30:0], mosi};
        sprev = sclk;
      end
      @(negedge PCLK);
    end
    SPICR_1 = cr1; clk_div = div; MWDATA = data; ss_sel = sel;
    $display("xfer cr1=%02h div=%0d sel=%0d tx=%08h rx=%08h busy_cycles=%0d mosi_bits=%08h",
             cr1, div, sel, data, MRDATA, cyc, cap);
  endtask

  initial begin
    int          cyc;
    int          edges;
    int          guard;
    logic        sprev;
    logic [31:0] cap;
    logic [3:0]  ss_seen;
    logic        ss_ok;
    logic [7:0]  cr1;

    // Reset state
    repeat (3) @(negedge PCLK);
    chk("rst_ss_n", ss_n, 4'hF);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mrdata", MRDATA, 32'h0);
    chk("rst_spisr", SPISR, 8'h20);
    PRESETn = 1'b0;
    @(negedge PCLK);

    // start ignored while SPE=0
    SPICR_1 = 8'h02; start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
    chk("spe0_busy", busy, 1'b0);
    chk("spe0_ss_n", ss_n, 4'hF);

    // Mode 0 loopback, clk_div=0
`ifdef SPI_MASTER_LOOPBACK_EN
    loop_ext = 1'b0;
`else
    loop_ext = 1'b1;
`endif
    SPICR_2 = 8'h02;
    do_xfer(8'h42, 8'd0, 32'hA5C30F96, 2'd0, cyc, cap, ss_seen, ss_ok);
    chk("lb_mrdata", MRDATA, 32'hA5C30F96);
    chk("lb_busy_cycles", cyc, 66);
    chk("lb_spisr", SPISR, 8'hA0);
    chk("lb_mosi_stream", cap, 32'hA5C30F96);
    chk("lb_ss_active", ss_seen, 4'hE);
    chk("lb_ss_stable", ss_ok, 1'b1);
    chk("lb_ss_after", ss_n, 4'hF);
    loop_ext = 1'b0;
    SPICR_2 = 8'h00;

    // Modes 1..3 against the slave model, clk_div=3, slave 2
    for (int m = 1; m < 4; m++) begin
      cr1 = 8'h42 | {4'b0, m[1:0], 2'b0};
      do_xfer(cr1, 8'd3, 32'h12345678, 2'd2, cyc, cap, ss_seen, ss_ok);
      chk($sformatf("mode%0d_mrdata", m), MRDATA, 32'h3C5A9601);
      chk($sformatf("mode%0d_busy_cycles", m), cyc, 264);
      chk($sformatf("mode%0d_sclk_idle", m), sclk, m[1]);
      chk($sformatf("mode%0d_mosi_stream", m), cap, 32'h12345678);
      chk($sformatf("mode%0d_ss_active", m), ss_seen, 4'hB);
      chk($sformatf("mode%0d_ss_stable", m), ss_ok, 1'b1);
    end

    // LSB first: one bit set at bit 0 goes out first; received MSB-first word lands reversed
    do_xfer(8'h43, 8'd1, 32'h00000001, 2'd0, cyc, cap, ss_seen, ss_ok);
    chk("lsb_mosi_stream", cap, 32'h80000000);
    chk("lsb_mrdata", MRDATA, 32'h80695A3C);
    chk("lsb_busy_cycles", cyc, 132);

    // SSOE=0: no select asserted, frame still runs
    do_xfer(8'h40, 8'd0, 32'hFFFF0000, 2'd2, cyc, cap, ss_seen, ss_ok);
    chk("nossoe_ss", ss_seen, 4'hF);
    chk("nossoe_ss_stable", ss_ok, 1'b1);
    chk("nossoe_mrdata", MRDATA, 32'h3C5A9601);
    chk("nossoe_busy_cycles", cyc, 66);

    // SPE dropped after 10 SCLK edges
    @(negedge PCLK);
    cur_cpol = 1'b0; cur_cpha = 1'b0;
    SPICR_1 = 8'h42; clk_div = 8'd1; MWDATA = 32'hDEADBEEF; ss_sel = 2'd1;
    @(negedge PCLK);
    start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
    edges = 0; guard = 0; sprev = 1'b0;
    while (edges < 10 && guard < 1000) begin
      if (sclk !== sprev) begin
        edges++;
        sprev = sclk;
      end
      if (edges < 10) begin
        @(negedge PCLK);
        guard++;
      end
    end
    chk("abort_edges_reached", edges, 10);
    chk("abort_ss_before", ss_n, 4'hD);
    SPICR_1 = 8'h02;
    @(negedge PCLK);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ss_n", ss_n, 4'hF);
    chk("abort_mrdata", MRDATA, 32'h3C5A9601);
    chk("abort_spisr", SPISR, 8'h20);
    chk("abort_sclk", sclk, 1'b0);
    chk("abort_mosi", mosi, 1'b0);
    $display("xfer aborted after %0d sclk edges", edges);

    // Reset with start in the middle of a mode-3 frame
    @(negedge PCLK);
    cur_cpol = 1'b1; cur_cpha = 1'b1;
    SPICR_1 = 8'h4E; clk_div = 8'd0; MWDATA = 32'hFFFFFFFF; ss_sel = 2'd3;
    @(negedge PCLK);
    start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
    repeat (20) @(negedge PCLK);
    chk("rstmid_busy_before", busy, 1'b1);
    PRESETn = 1'b1; start = 1'b1;
    @(negedge PCLK);
    chk("rstmid_ss_n", ss_n, 4'hF);
    chk("rstmid_sclk", sclk, 1'b0);
    chk("rstmid_mosi", mosi, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_mrdata", MRDATA, 32'h0);
    chk("rstmid_spisr", SPISR, 8'h20);
    PRESETn = 1'b0; start = 1'b0;
    @(negedge PCLK);
    chk("rstmid_no_start", busy, 1'b0);
    $display("xfer interrupted by reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_gen.md
SPI_MASTER_GEN -- requirements
Module: spi_master_gen

Interface
REQ-001 Parameter DATA_W, default 32, frame length in bits; legal values are multiples of 8 from 8 to 64.
REQ-002 Parameter NUM_SS, default 4, number of slave-select outputs; legal range is 1 to 8.
REQ-003 Parameter DIV_W, default 8, width of the SCLK divider input.
REQ-004 Port PCLK, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-005 Port PRESETn, input, 1 bit: synchronous, active-high reset (reset asserted when PRESETn=1).
REQ-006 Port start, input, 1 bit: transfer request, sampled in IDLE.
REQ-007 Port MWDATA, input, DATA_W bits: transmit word.
REQ-008 Port ss_sel, input, $clog2(NUM_SS) bits (min 1): slave index.
REQ-009 Port SPICR_1, input, 8 bits: 6=SPE, 3=CPOL, 2=CPHA, 1=SSOE, 0=LSBFE; other bits ignored.
REQ-010 Port SPICR_2, input, 8 bits: 1=LOOPB; other bits ignored.
REQ-011 Port clk_div, input, DIV_W bits: SCLK half-period = clk_div+1 PCLK cycles.
REQ-012 Port miso, input, 1 bit: serial receive data.
REQ-013 Port MRDATA, output, DATA_W bits: last completed receive word.
REQ-014 Port SPISR, output, 8 bits: 7=SPIF, 5=SPTEF; other bits read 0.
REQ-015 Port busy, output, 1 bit: high from start acceptance to return to IDLE.
REQ-016 Ports ss_n (output, NUM_SS bits, active-low selects), sclk (output, 1 bit), mosi (output, 1 bit).

Function
REQ-017 The FSM shall have states IDLE, SETUP, XFER and HOLD.
REQ-018 In IDLE, start=1 with SPE=1 shall be accepted: latch MWDATA, SPICR_1, clk_div and ss_sel; clear SPTEF and SPIF; set busy; go to SETUP.
REQ-019 start shall be ignored when SPE=0 or outside IDLE.
REQ-020 SETUP shall last clk_div+1 cycles: ss_n[ss_sel]=0 if SSOE=1, otherwise all ss_n stay 1; sclk=CPOL; for CPHA=0, mosi carries the first bit.
REQ-021 XFER shall generate 2*DATA_W SCLK edges, each half-period apart, starting from level CPOL.
REQ-022 CPHA=0: sample receive data on each leading edge; drive the next mosi bit on each trailing edge.
REQ-023 CPHA=1: drive the mosi bit on each leading edge; sample on each trailing edge.
REQ-024 LSBFE=0: send MWDATA[DATA_W-1] first, and the first received bit lands in MRDATA[DATA_W-1]. LSBFE=1: bit 0 first, and the first received bit lands in MRDATA[0].
REQ-025 HOLD shall last clk_div+1 cycles with sclk=CPOL. On exit: all ss_n=1, MRDATA loaded, SPIF=1, SPTEF=1, busy=0, next state IDLE.
REQ-026 busy shall stay high for exactly (2*DATA_W+2)*(clk_div+1) cycles per completed transfer.
REQ-027 SPIF shall hold until the next accepted start; SPTEF shall be 1 whenever busy=0.
REQ-028 SPE cleared during SETUP/XFER/HOLD shall, on the next cycle: go to IDLE, set all ss_n=1, sclk=CPOL, mosi=0, busy=0, SPTEF=1; MRDATA and SPIF stay unchanged.
REQ-029 Changes on SPICR_1, clk_div or ss_sel during a transfer shall have no effect, except SPE.
REQ-030 An ss_sel value >= NUM_SS shall assert no select; the transfer still runs.

Reset
REQ-031 While PRESETn=1 at a PCLK edge: state=IDLE, ss_n all 1, sclk=0, mosi=0, busy=0, MRDATA=0, SPISR=8'h20; internal counters cleared.
REQ-032 Reset shall override all other inputs, including a start in the same cycle, and abort any transfer in progress.

Configuration
REQ-033 Macro SPI_MASTER_LOOPBACK_EN defined: when LOOPB=1, the receive path samples the internal mosi and ignores miso; ss_n and sclk behave normally.
REQ-034 Macro SPI_MASTER_LOOPBACK_EN undefined: LOOPB is ignored and the loopback logic is not present; miso is always sampled.

Verification
REQ-035 Mode 0, LOOPB=1 (macro defined), DATA_W=32, clk_div=0, MWDATA=32'hA5C30F96 -> MRDATA=32'hA5C30F96, busy high 66 cycles, SPISR=8'hA0 afterwards.
REQ-036 Modes 1/2/3 each, slave model returning 32'h3C5A9601 on miso, clk_div=3 -> MRDATA=32'h3C5A9601; sclk idles at CPOL; 264 busy cycles.
REQ-037 LSBFE=1, MWDATA=32'h00000001 -> first mosi bit 1, then 31 zeros.
REQ-038 ss_sel=2, SSOE=1 -> only ss_n[2] low, during SETUP through HOLD. SSOE=0 -> ss_n stays 4'hF.
REQ-039 SPE dropped after 10 SCLK edges -> IDLE next cycle, ss_n=4'hF, MRDATA unchanged, SPIF=0.
REQ-040 PRESETn pulsed mid-XFER together with start -> all outputs at reset values next cycle, no transfer begins.
